// File: rtl/leaf_refill_scheduler.sv
// Keeps the merger tree's leaf FIFOs topped up: reserves leaf credit, issues round-robin line
// reads, and serializes returned lines into the tagged leaf FIFO one record per cycle.
module leaf_refill_scheduler #(
    parameter int unsigned NUM_LEAVES   = 128,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned LINE_RECORDS = 16,
    parameter int unsigned LEAF_DEPTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_start,
    input  logic [ADDR_WIDTH-1:0]              i_base,
    input  logic [15:0]                        i_run_lines,
    output logic                               o_req_valid,
    input  logic                               i_req_ready,
    output logic [ADDR_WIDTH-1:0]              o_req_addr,
    output logic [$clog2(NUM_LEAVES)-1:0]      o_req_leaf,
    input  logic                               i_resp_valid,
    output logic                               o_resp_ready,
    input  logic [$clog2(NUM_LEAVES)-1:0]      i_resp_leaf,
    input  logic [LINE_RECORDS*DATA_WIDTH-1:0] i_resp_data,
    output logic [NUM_LEAVES-1:0]              o_leaf_write,
    output logic [DATA_WIDTH-1:0]              o_leaf_data,
    input  logic [NUM_LEAVES-1:0]              i_leaf_read,
    output logic                               o_busy,
    output logic                               o_done
);

    localparam int unsigned LEAF_W     = $clog2(NUM_LEAVES);
    localparam int unsigned CREDIT_W   = $clog2(LEAF_DEPTH + 1);
    localparam int unsigned CNT_W      = (LINE_RECORDS > 1) ? $clog2(LINE_RECORDS) : 1;
    localparam int unsigned LINE_BYTES = LINE_RECORDS * DATA_WIDTH / 8;
    localparam int unsigned OUTS_W     = $clog2(NUM_LEAVES * (LEAF_DEPTH / LINE_RECORDS) + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                  state_q, state_d;
    logic [CREDIT_W-1:0]     credit_q    [NUM_LEAVES];
    logic [CREDIT_W-1:0]     credit_d    [NUM_LEAVES];
    logic [15:0]             remain_q    [NUM_LEAVES];
    logic [15:0]             remain_d    [NUM_LEAVES];
    logic [15:0]             next_line_q [NUM_LEAVES];
    logic [15:0]             next_line_d [NUM_LEAVES];
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [15:0]             run_lines_q, run_lines_d;
    logic [OUTS_W-1:0]       outstanding_q, outstanding_d;
    logic [LEAF_W-1:0]       rr_ptr_q, rr_ptr_d;

    logic                    req_valid_q, req_valid_d;
    logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
    logic [LEAF_W-1:0]       req_leaf_q, req_leaf_d;

    logic                               ser_active_q, ser_active_d;
    logic [CNT_W-1:0]                   ser_cnt_q, ser_cnt_d;
    logic [LEAF_W-1:0]                  ser_leaf_q, ser_leaf_d;
    logic [LINE_RECORDS*DATA_WIDTH-1:0] ser_line_q, ser_line_d;

    logic [NUM_LEAVES-1:0]   eligible;
    logic                    can_load;
    logic                    grant;
    logic [LEAF_W-1:0]       grant_idx;
    logic [ADDR_WIDTH-1:0]   grant_addr;
    logic                    req_hs;
    logic                    resp_hs;
    logic                    ser_last;
    logic                    ser_draining;
    logic                    all_remain_zero;
    logic                    start_job;

    assign start_job = (state_q == StIdle) && i_start;
    assign req_hs    = req_valid_q && i_req_ready;
    assign can_load  = !req_valid_q || i_req_ready;

    assign ser_last     = (ser_cnt_q == CNT_W'(LINE_RECORDS - 1));
    assign o_resp_ready = !ser_active_q || ser_last;
    assign resp_hs      = i_resp_valid && o_resp_ready;
    // Serializer counts as idle during its final record unless a new line is taken in.
    assign ser_draining = !ser_active_q || (ser_last && !resp_hs);

    always_comb begin
        eligible        = '0;
        all_remain_zero = 1'b1;
        for (int unsigned k = 0; k < NUM_LEAVES; k++) begin
            eligible[k] = (state_q == StRun) && (credit_q[k] >= CREDIT_W'(LINE_RECORDS))
                          && (remain_q[k] != 16'd0);
            if (remain_q[k] != 16'd0) begin
                all_remain_zero = 1'b0;
            end
        end
    end

    // Round-robin search starting at the pointer, which holds last grant + 1.
    always_comb begin
        grant     = 1'b0;
        grant_idx = '0;
        for (int unsigned i = 0; i < NUM_LEAVES; i++) begin
            logic [LEAF_W-1:0] cand;
            cand = LEAF_W'((32'(rr_ptr_q) + i) % NUM_LEAVES);
            if (!grant && eligible[cand]) begin
                grant     = 1'b1;
                grant_idx = cand;
            end
        end
        if (!can_load) begin
            grant = 1'b0;
        end
    end

    assign grant_addr = base_q + (ADDR_WIDTH'(grant_idx) * ADDR_WIDTH'(run_lines_q)
                                  + ADDR_WIDTH'(next_line_q[grant_idx]))
                                 * ADDR_WIDTH'(LINE_BYTES);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (i_start) state_d = StRun;
            StRun: begin
                if (all_remain_zero && (outstanding_q == '0) && !req_valid_q && ser_draining) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        base_d        = base_q;
        run_lines_d   = run_lines_q;
        outstanding_d = outstanding_q;
        rr_ptr_d      = rr_ptr_q;
        req_valid_d   = req_valid_q;
        req_addr_d    = req_addr_q;
        req_leaf_d    = req_leaf_q;
        remain_d      = remain_q;
        next_line_d   = next_line_q;

        for (int unsigned k = 0; k < NUM_LEAVES; k++) begin
            credit_d[k] = credit_q[k] + CREDIT_W'(i_leaf_read[k]);
            if (grant && (32'(grant_idx) == k)) begin
                credit_d[k] = credit_d[k] - CREDIT_W'(LINE_RECORDS);
            end
        end

        if (req_hs) begin
            req_valid_d = 1'b0;
        end
        if (grant) begin
            req_valid_d              = 1'b1;
            req_leaf_d               = grant_idx;
            req_addr_d               = grant_addr;
            rr_ptr_d                 = LEAF_W'((32'(grant_idx) + 32'd1) % NUM_LEAVES);
            remain_d[grant_idx]      = remain_q[grant_idx] - 16'd1;
            next_line_d[grant_idx]   = next_line_q[grant_idx] + 16'd1;
        end

        if (start_job) begin
            base_d        = i_base;
            run_lines_d   = i_run_lines;
            outstanding_d = '0;
            for (int unsigned k = 0; k < NUM_LEAVES; k++) begin
                remain_d[k]    = i_run_lines;
                next_line_d[k] = 16'd0;
            end
        end else if (req_hs && !resp_hs) begin
            outstanding_d = outstanding_q + OUTS_W'(1);
        end else if (!req_hs && resp_hs) begin
            outstanding_d = outstanding_q - OUTS_W'(1);
        end
    end

    always_comb begin
        ser_active_d = ser_active_q;
        ser_cnt_d    = ser_cnt_q;
        ser_leaf_d   = ser_leaf_q;
        ser_line_d   = ser_line_q;
        if (resp_hs) begin
            ser_active_d = 1'b1;
            ser_cnt_d    = '0;
            ser_leaf_d   = i_resp_leaf;
            ser_line_d   = i_resp_data;
        end else if (ser_active_q) begin
            if (ser_last) begin
                ser_active_d = 1'b0;
            end else begin
                ser_cnt_d = ser_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        o_leaf_write = '0;
        o_leaf_data  = '0;
        if (ser_active_q) begin
            o_leaf_write[ser_leaf_q] = 1'b1;
            o_leaf_data              = ser_line_q[32'(ser_cnt_q) * DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign o_req_valid = req_valid_q;
    assign o_req_addr  = req_addr_q;
    assign o_req_leaf  = req_leaf_q;
    assign o_busy      = (state_q == StRun);
    assign o_done      = (state_q == StDone);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= StIdle;
            base_q        <= '0;
            run_lines_q   <= '0;
            outstanding_q <= '0;
            rr_ptr_q      <= '0;
            req_valid_q   <= 1'b0;
            req_addr_q    <= '0;
            req_leaf_q    <= '0;
            ser_active_q  <= 1'b0;
            ser_cnt_q     <= '0;
            ser_leaf_q    <= '0;
            ser_line_q    <= '0;
            for (int unsigned k = 0; k < NUM_LEAVES; k++) begin
                credit_q[k]    <= CREDIT_W'(LEAF_DEPTH);
                remain_q[k]    <= '0;
                next_line_q[k] <= '0;
            end
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            run_lines_q   <= run_lines_d;
            outstanding_q <= outstanding_d;
            rr_ptr_q      <= rr_ptr_d;
            req_valid_q   <= req_valid_d;
            req_addr_q    <= req_addr_d;
            req_leaf_q    <= req_leaf_d;
            ser_active_q  <= ser_active_d;
            ser_cnt_q     <= ser_cnt_d;
            ser_leaf_q    <= ser_leaf_d;
            ser_line_q    <= ser_line_d;
            for (int unsigned k = 0; k < NUM_LEAVES; k++) begin
                credit_q[k]    <= credit_d[k];
                remain_q[k]    <= remain_d[k];
                next_line_q[k] <= next_line_d[k];
            end
        end
    end

endmodule

// File: tb/tb_leaf_refill_scheduler.sv
// Directed bench for leaf_refill_scheduler: startup, backpressure, refill, serializer,
// mid-run reset and completion, with hand-computed expectations.
module tb_leaf_refill_scheduler;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [31:0]  base;
    logic [15:0]  run_lines;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic [6:0]   req_leaf;
    logic         resp_valid;
    logic         resp_ready;
    logic [6:0]   resp_leaf;
    logic [511:0] resp_data;
    logic [127:0] leaf_write;
    logic [31:0]  leaf_data;
    logic [127:0] leaf_read;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    logic [6:0]  q_leaf[$];
    logic [31:0] q_addr[$];
    int          q_cyc[$];

    leaf_refill_scheduler dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_base       (base),
        .i_run_lines  (run_lines),
        .o_req_valid  (req_valid),
        .i_req_ready  (req_ready),
        .o_req_addr   (req_addr),
        .o_req_leaf   (req_leaf),
        .i_resp_valid (resp_valid),
        .o_resp_ready (resp_ready),
        .i_resp_leaf  (resp_leaf),
        .i_resp_data  (resp_data),
        .o_leaf_write (leaf_write),
        .o_leaf_data  (leaf_data),
        .i_leaf_read  (leaf_read),
        .o_busy       (busy),
        .o_done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (rst_n && done) done_cnt++;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_valid"}, 128'(req_valid), 128'd0);
        check({tag, " req_addr"}, 128'(req_addr), 128'd0);
        check({tag, " req_leaf"}, 128'(req_leaf), 128'd0);
        check({tag, " resp_ready"}, 128'(resp_ready), 128'd1);
        check({tag, " leaf_write"}, 128'(leaf_write), 128'd0);
        check({tag, " leaf_data"}, 128'(leaf_data), 128'd0);
        check({tag, " busy"}, 128'(busy), 128'd0);
        check({tag, " done"}, 128'(done), 128'd0);
    endtask

    // Records every request that handshakes over the given number of cycles.
    task automatic collect(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            if (req_valid && req_ready) begin
                q_leaf.push_back(req_leaf);
                q_addr.push_back(req_addr);
                q_cyc.push_back(c);
            end
            step();
        end
    endtask

    task automatic clear_log();
        q_leaf.delete();
        q_addr.delete();
        q_cyc.delete();
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        logic [511:0] line;
        int           waited;
        rst_n      = 1'b0;
        start      = 1'b0;
        base       = '0;
        run_lines  = '0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_leaf  = '0;
        resp_data  = '0;
        leaf_read  = '0;
        #12;
        check_reset_outputs("reset");
        check("reset credit0", 128'(dut.credit_q[0]), 128'd32);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Startup: two full rounds of requests, leaves in order.
        base      = 32'h1000;
        run_lines = 16'd2;
        req_ready = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        check("start+1 req_valid", 128'(req_valid), 128'd0);
        step();
        check("start+2 req_valid", 128'(req_valid), 128'd1);
        collect(300);
        check("startup count", 128'(q_leaf.size()), 128'd256);
        for (int n = 0; n < 256 && n < q_leaf.size(); n++) begin
            check($sformatf("startup leaf %0d", n), 128'(q_leaf[n]), 128'(n % 128));
            check($sformatf("startup addr %0d", n), 128'(q_addr[n]),
                  128'(32'h1000 + ((n % 128) * 2 + n / 128) * 64));
        end
        check("startup credit0", 128'(dut.credit_q[0]), 128'd0);
        check("startup credit127", 128'(dut.credit_q[127]), 128'd0);
        check("startup busy", 128'(busy), 128'd1);

        // Serializer: line tagged 9 (record j = j+1), then a second line back-to-back.
        for (int j = 0; j < 16; j++) line[j*32 +: 32] = 32'(j + 1);
        check("ser idle ready", 128'(resp_ready), 128'd1);
        resp_valid = 1'b1;
        resp_leaf  = 7'd9;
        resp_data  = line;
        step();
        resp_valid = 1'b0;
        for (int j = 0; j < 16; j++) line[j*32 +: 32] = 32'(32'h100 + j);
        for (int j = 0; j < 16; j++) begin
            check($sformatf("ser write %0d", j), 128'(leaf_write), 128'(1) << 9);
            check($sformatf("ser data %0d", j), 128'(leaf_data), 128'(j + 1));
            if (j == 0) check("ser ready first", 128'(resp_ready), 128'd0);
            if (j == 15) begin
                check("ser ready last", 128'(resp_ready), 128'd1);
                resp_valid = 1'b1;
                resp_leaf  = 7'd10;
                resp_data  = line;
            end
            step();
        end
        resp_valid = 1'b0;
        check("ser2 write", 128'(leaf_write), 128'(1) << 10);
        check("ser2 data", 128'(leaf_data), 128'h100);
        do_reset();

        // Backpressure: first request held for 5 cycles with a single reservation.
        clear_log();
        base      = 32'h2000;
        run_lines = 16'd3;
        req_ready = 1'b0;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp valid %0d", c), 128'(req_valid), 128'd1);
            check($sformatf("bp leaf %0d", c), 128'(req_leaf), 128'd0);
            check($sformatf("bp addr %0d", c), 128'(req_addr), 128'h2000);
            step();
        end
        check("bp credit0", 128'(dut.credit_q[0]), 128'd16);
        check("bp credit1", 128'(dut.credit_q[1]), 128'd32);
        req_ready = 1'b1;
        collect(300);
        check("bp count", 128'(q_leaf.size()), 128'd256);

        // Refill: leaf 7 regains credit first; leaf 5's 16th read follows one that
        // coincides with leaf 7's grant.
        clear_log();
        for (int t = 0; t < 30; t++) begin
            leaf_read    = '0;
            leaf_read[7] = (t <= 15);
            leaf_read[5] = (t <= 14) || (t == 16);
            if (req_valid) begin
                q_leaf.push_back(req_leaf);
                q_addr.push_back(req_addr);
                q_cyc.push_back(t);
            end
            step();
        end
        leaf_read = '0;
        check("refill count", 128'(q_leaf.size()), 128'd2);
        if (q_leaf.size() == 2) begin
            check("refill leaf a", 128'(q_leaf[0]), 128'd7);
            check("refill addr a", 128'(q_addr[0]), 128'h25C0);
            check("refill cyc a", 128'(q_cyc[0]), 128'd17);
            check("refill leaf b", 128'(q_leaf[1]), 128'd5);
            check("refill addr b", 128'(q_addr[1]), 128'h2440);
            check("refill cyc b", 128'(q_cyc[1]), 128'd18);
        end
        do_reset();

        // Reset with three requests outstanding and a fourth held.
        base      = 32'h0;
        run_lines = 16'd1;
        req_ready = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        step();
        req_ready = 1'b0;
        check("mid outstanding", 128'(dut.outstanding_q), 128'd3);
        check("mid held leaf", 128'(req_leaf), 128'd3);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        check("midreset credit0", 128'(dut.credit_q[0]), 128'd32);
        check("midreset credit3", 128'(dut.credit_q[3]), 128'd32);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Completion with responses returned in reverse order.
        clear_log();
        base      = 32'h4000;
        run_lines = 16'd1;
        req_ready = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        collect(140);
        check("done req count", 128'(q_leaf.size()), 128'd128);
        for (int i = q_leaf.size() - 1; i >= 0; i--) begin
            for (int j = 0; j < 16; j++) line[j*32 +: 32] = (32'(q_leaf[i]) << 8) | 32'(j);
            resp_valid = 1'b1;
            resp_leaf  = q_leaf[i];
            resp_data  = line;
            waited     = 0;
            while (!resp_ready && waited < 40) begin
                step();
                waited++;
            end
            if (!resp_ready) check($sformatf("resp wait %0d", i), 128'(resp_ready), 128'd1);
            step();
            resp_valid = 1'b0;
        end
        check("done early", 128'(done_cnt), 128'd0);
        for (int j = 0; j < 16; j++) begin
            check($sformatf("last write %0d", j), 128'(leaf_write), 128'(1) << q_leaf[0]);
            check($sformatf("last data %0d", j), 128'(leaf_data),
                  128'((32'(q_leaf[0]) << 8) | 32'(j)));
            check($sformatf("last done %0d", j), 128'(done), 128'd0);
            if (j == 15) check("last busy", 128'(busy), 128'd1);
            step();
        end
        check("done pulse", 128'(done), 128'd1);
        check("done busy", 128'(busy), 128'd0);
        check("done write", 128'(leaf_write), 128'd0);
        step();
        check("done clear", 128'(done), 128'd0);
        check("done count", 128'(done_cnt), 128'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
